// File: rtl/data_memory_if.sv
// Load/store port of the data memory: address, write strobe and data in, read data out.
// The memory drives only D_out; the memory stage of the datapath drives everything else.
interface data_memory_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] ADDR;
    logic                  WE;
    logic [DATA_WIDTH-1:0] D_in;
    logic [DATA_WIDTH-1:0] D_out;

    modport master (output ADDR, output WE, output D_in, input  D_out);
    modport slave  (input  ADDR, input  WE, input  D_in, output D_out);
endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM for the RISC-V memory stage: synchronous write, combinational read.
// An asynchronous active-low reset clears the whole array.
module data_memory #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic          CLK,
    input  logic          RST_N,
    data_memory_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_rdata;

    // Flop array rather than block RAM, so every word can be cleared at once on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.WE) begin
            r_mem[bus.ADDR] <= bus.D_in;
        end
    end

    assign w_rdata   = r_mem[bus.ADDR];
    assign bus.D_out = w_rdata;
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: reset clear, write/hold, addressing,
// read-during-write, asynchronous reset mid-operation and back-to-back writes.
`timescale 1ns/1ps
module tb_data_memory;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 64;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    data_memory_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    data_memory #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case something upstream of the checks never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        bus.WE   = 1'b0;
        bus.ADDR = '0;
        bus.D_in = 64'hDEAD_BEEF_DEAD_BEEF;
        RST_N    = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.ADDR = a[ADDR_WIDTH-1:0];
            #1;
            checks++;
            if (bus.D_out !== 64'd0) begin
                failures++;
                $display("[TB] FAIL reset_clear addr=%0d actual=%h expected=%h", a, bus.D_out, 64'd0);
            end
        end
    endtask

    task automatic test_write_hold();
        @(negedge CLK);
        bus.WE   = 1'b1;
        bus.D_in = 64'd150;
        bus.ADDR = 5'd11;
        #1;
        checks++;
        if (bus.D_out !== 64'd0) begin
            failures++;
            $display("[TB] FAIL write_before_edge actual=%0d expected=%0d", bus.D_out, 0);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (bus.D_out !== 64'd150) begin
                failures++;
                $display("[TB] FAIL write_after_edge cycle=%0d actual=%0d expected=%0d", c, bus.D_out, 150);
            end
        end
        @(negedge CLK);
        bus.WE   = 1'b0;
        bus.D_in = 64'd300;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (bus.D_out !== 64'd150) begin
                failures++;
                $display("[TB] FAIL hold cycle=%0d actual=%0d expected=%0d", c, bus.D_out, 150);
            end
        end
    endtask

    task automatic test_addr_independence();
        logic [DATA_WIDTH-1:0] expected [3];
        logic [ADDR_WIDTH-1:0] addrs    [3];
        expected[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        expected[1] = 64'h5555_5555_5555_5555;
        expected[2] = 64'd0;
        addrs[0] = 5'd0;
        addrs[1] = 5'd31;
        addrs[2] = 5'd15;
        @(negedge CLK);
        bus.WE   = 1'b1;
        bus.ADDR = 5'd0;
        bus.D_in = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge CLK);
        bus.ADDR = 5'd31;
        bus.D_in = 64'h5555_5555_5555_5555;
        @(negedge CLK);
        bus.WE   = 1'b0;
        bus.D_in = 64'd0;
        for (int k = 0; k < 3; k++) begin
            bus.ADDR = addrs[k];
            #1;
            checks++;
            if (bus.D_out !== expected[k]) begin
                failures++;
                $display("[TB] FAIL addr_indep addr=%0d actual=%h expected=%h", addrs[k], bus.D_out, expected[k]);
            end
        end
    endtask

    task automatic test_read_during_write();
        @(negedge CLK);
        bus.WE   = 1'b1;
        bus.ADDR = 5'd7;
        bus.D_in = 64'd1;
        @(negedge CLK);
        bus.D_in = 64'd2;
        #1;
        checks++;
        if (bus.D_out !== 64'd1) begin
            failures++;
            $display("[TB] FAIL rdw_old actual=%0d expected=%0d", bus.D_out, 1);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.D_out !== 64'd2) begin
            failures++;
            $display("[TB] FAIL rdw_new actual=%0d expected=%0d", bus.D_out, 2);
        end
        @(negedge CLK);
        bus.D_in = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.D_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL rdw_all_ones actual=%h expected=%h", bus.D_out, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        @(negedge CLK);
        bus.WE = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        bus.WE   = 1'b1;
        bus.ADDR = 5'd11;
        bus.D_in = 64'd150;
        @(negedge CLK);
        bus.WE = 1'b0;
        #1;
        checks++;
        if (bus.D_out !== 64'd150) begin
            failures++;
            $display("[TB] FAIL async_pre actual=%0d expected=%0d", bus.D_out, 150);
        end
        #1;
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.D_out !== 64'd0) begin
            failures++;
            $display("[TB] FAIL async_immediate actual=%0d expected=%0d", bus.D_out, 0);
        end
        bus.WE   = 1'b1;
        bus.D_in = 64'd999;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.D_out !== 64'd0) begin
            failures++;
            $display("[TB] FAIL async_write_ignored actual=%0d expected=%0d", bus.D_out, 0);
        end
        bus.ADDR = 5'd7;
        #1;
        checks++;
        if (bus.D_out !== 64'd0) begin
            failures++;
            $display("[TB] FAIL async_other_word actual=%h expected=%h", bus.D_out, 64'd0);
        end
        @(negedge CLK);
        bus.WE   = 1'b0;
        bus.ADDR = 5'd11;
        RST_N    = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.D_out !== 64'd0) begin
            failures++;
            $display("[TB] FAIL async_after_release actual=%0d expected=%0d", bus.D_out, 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            bus.WE   = 1'b1;
            bus.ADDR = i[ADDR_WIDTH-1:0];
            bus.D_in = 64'(i + 1);
        end
        @(negedge CLK);
        bus.WE   = 1'b0;
        bus.D_in = 64'd0;
        for (int i = 0; i < 32; i++) begin
            bus.ADDR = i[ADDR_WIDTH-1:0];
            #1;
            checks++;
            if (bus.D_out !== 64'(i + 1)) begin
                failures++;
                $display("[TB] FAIL b2b addr=%0d actual=%0d expected=%0d", i, bus.D_out, i + 1);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_hold();
        test_addr_independence();
        test_read_during_write();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
